snake_step_ctrl: RTL and testbench
==================================

SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clock cycles per snake step (>=2).
REQ-002 SHALL have parameter MAX_LEN, default 8, meaning the maximum number of snake segments.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, meaning a game-start request, sampled in IDLE and DEAD.
REQ-006 SHALL have port turn_l and turn_r, input, 1 each, meaning relative left/right turn requests.
REQ-007 SHALL have port food_x, food_y, food_vld, input, 3/3/1, meaning the food cell and its valid flag.
REQ-008 SHALL have port q_x, q_y, input, 3 each, meaning the field cell-query address.
REQ-009 SHALL have port q_hit, output, 1, meaning the queried cell holds a snake segment (combinational).
REQ-010 SHALL have port head_x, head_y, output, 3 each, meaning the head position.
REQ-011 SHALL have port dir, output, 2, meaning direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-012 SHALL have port length, output, 4, meaning the current segment count.
REQ-013 SHALL have port step, eaten, dead, output, 1 each, meaning a step-done pulse, a food-eaten pulse, and the game-over level.

Function
REQ-014 SHALL implement the states IDLE, RUN and DEAD, with the state visible only through outputs.
REQ-015 SHALL move from IDLE to RUN on start=1, reloading the head to (0,0), dir to 01, length to 1 and the tick counter to 0.
REQ-016 SHALL, in RUN, count 0..TICK_DIV-1 and issue a step on the cycle where the count equals TICK_DIV-1; the count then wraps to 0.
REQ-017 SHALL latch a pending turn between steps: turn_l sets dir-1 mod 4, turn_r sets dir+1 mod 4; the first request wins and later ones are ignored until the next step.
REQ-018 SHALL ignore a turn when turn_l and turn_r are asserted in the same cycle with none pending.
REQ-019 SHALL, at a step, apply the pending turn first, compute the new head, then clear the pending turn.
REQ-020 SHALL keep segment positions in a MAX_LEN-deep shift array; index 0 is the head.
REQ-021 SHALL, at a step, shift segment i into i+1 and write the new head to index 0.
REQ-022 SHALL treat a step as growth when food_vld=1 and the new head equals (food_x,food_y): length increments, saturating at MAX_LEN, and eaten pulses for 1 cycle.
REQ-023 SHALL detect a wall hit: the head at x=7 moving right, x=0 moving left, y=0 moving up, or y=7 moving down.
REQ-024 SHALL detect self-collision: the new head equals any segment with index below length-1, or equal to length-1 when growing.
REQ-025 SHALL, on a wall hit or self-collision, enter DEAD without updating the head, segments or length, and set dead=1.
REQ-026 SHALL register its outputs: head, dir, length, step and eaten update the cycle after the tick cycle, and step pulses 1 cycle per legal step.
REQ-027 SHALL assert q_hit iff some index i<length holds (q_x,q_y).
REQ-028 SHALL, in DEAD, hold all positions, ignore turns, and return to RUN on start=1 with the same reload as REQ-015.
REQ-029 SHALL ignore turns in IDLE.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-step, immediately set: state IDLE, head (0,0), dir 01, length 1, all segments (0,0), pending turn cleared, counter 0, step=0, eaten=0, dead=0.

Verification
REQ-031 SHALL cover straight run: start, no turns, 7 ticks -> head (7,0), 7 step pulses spaced TICK_DIV cycles, then the next tick gives dead=1 with the head still (7,0).
REQ-032 SHALL cover turns: after 2 steps right, turn_r -> dir=10, next step head (2,1); simultaneous turn_l+turn_r -> dir unchanged.
REQ-033 SHALL cover food: food at (1,0) valid, first step -> eaten pulse, length=2, q_hit at (0,0) and (1,0).
REQ-034 SHALL cover self-collision: length 5 forming a loop (right, down, left, up) -> dead=1, length held at 5.
REQ-035 SHALL cover reset mid-run: assert rst at head (3,2) -> all outputs at reset values that cycle; start then resumes from (0,0).
REQ-036 SHALL cover saturation: eat MAX_LEN+1 foods -> length stays 8, and eaten still pulses each time.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// Snake game step controller: tick divider, IDLE/RUN/DEAD sequencing, segment shift array,
// wall and self-collision detection, and a combinational cell-occupancy query port.
module snake_step_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int MAX_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       turn_l,
    input  logic       turn_r,
    input  logic [2:0] food_x,
    input  logic [2:0] food_y,
    input  logic       food_vld,
    input  logic [2:0] q_x,
    input  logic [2:0] q_y,
    output logic       q_hit,
    output logic [2:0] head_x,
    output logic [2:0] head_y,
    output logic [1:0] dir,
    output logic [3:0] length,
    output logic       step,
    output logic       eaten,
    output logic       dead
);

    // state  | meaning
    // S_IDLE | after reset, waiting for start
    // S_RUN  | counting ticks, stepping the snake
    // S_DEAD | wall or self hit, positions frozen until start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]     LEN_MAX  = 4'(MAX_LEN);

    state_t        state_q, state_d;
    logic [2:0]    seg_x_q [MAX_LEN];
    logic [2:0]    seg_x_d [MAX_LEN];
    logic [2:0]    seg_y_q [MAX_LEN];
    logic [2:0]    seg_y_d [MAX_LEN];
    logic [1:0]    dir_q, dir_d;
    logic [3:0]    len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_r_q, pend_r_d;
    logic          step_q, step_d;
    logic          eaten_q, eaten_d;

    logic          eff_vld, eff_r;
    logic [1:0]    nd;
    logic [2:0]    nh_x, nh_y;
    logic          wall, grow, self_hit;

    // A request arriving on the tick cycle itself still takes effect at that step.
    always_comb begin
        eff_vld = pend_vld_q;
        eff_r   = pend_r_q;
        if (!pend_vld_q && (turn_l ^ turn_r)) begin
            eff_vld = 1'b1;
            eff_r   = turn_r;
        end
        nd = dir_q;
        if (eff_vld) nd = eff_r ? dir_q + 2'd1 : dir_q - 2'd1;

        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        wall = 1'b0;
        case (nd)
            2'b00: begin wall = (seg_y_q[0] == 3'd0); nh_y = seg_y_q[0] - 3'd1; end
            2'b01: begin wall = (seg_x_q[0] == 3'd7); nh_x = seg_x_q[0] + 3'd1; end
            2'b10: begin wall = (seg_y_q[0] == 3'd7); nh_y = seg_y_q[0] + 3'd1; end
            default: begin wall = (seg_x_q[0] == 3'd0); nh_x = seg_x_q[0] - 3'd1; end
        endcase

        grow = food_vld && (nh_x == food_x) && (nh_y == food_y);

        // The tail vacates its cell on a plain step, so it only counts when growing.
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y) &&
                ((i < int'(len_q) - 1) || (grow && (i == int'(len_q) - 1))))
                self_hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        dir_d      = dir_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_r_d   = pend_r_q;
        step_d     = 1'b0;
        eaten_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DEAD: begin
                if (start) begin
                    state_d    = S_RUN;
                    dir_d      = 2'b01;
                    len_d      = 4'd1;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    pend_r_d   = 1'b0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = 3'd0;
                        seg_y_d[i] = 3'd0;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    if (wall || self_hit) begin
                        state_d = S_DEAD;
                    end else begin
                        step_d  = 1'b1;
                        eaten_d = grow;
                        dir_d   = nd;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y;
                        if (grow && (len_q < LEN_MAX)) len_d = len_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!pend_vld_q && (turn_l ^ turn_r)) begin
                        pend_vld_d = 1'b1;
                        pend_r_d   = turn_r;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dir_q      <= 2'b01;
            len_q      <= 4'd1;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_r_q   <= 1'b0;
            step_q     <= 1'b0;
            eaten_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= 3'd0;
                seg_y_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_r_q   <= pend_r_d;
            step_q     <= step_d;
            eaten_q    <= eaten_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y))
                q_hit = 1'b1;
        end
    end

    assign head_x = seg_x_q[0];
    assign head_y = seg_y_q[0];
    assign dir    = dir_q;
    assign length = len_q;
    assign step   = step_q;
    assign eaten  = eaten_q;
    assign dead   = (state_q == S_DEAD);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: straight run into the wall, turns, reset mid-run,
// food growth, self-collision and length saturation, all with hand-derived expectations.
module tb_snake_step_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, turn_l, turn_r, food_vld;
    logic [2:0] food_x, food_y, q_x, q_y;
    logic       q_hit, step, eaten, dead;
    logic [2:0] head_x, head_y;
    logic [1:0] dir;
    logic [3:0] length;

    int vecs = 0;
    int errs = 0;
    int n;

    always #5 clk = ~clk;

    snake_step_ctrl #(.TICK_DIV(4), .MAX_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .turn_l(turn_l), .turn_r(turn_r),
        .food_x(food_x), .food_y(food_y), .food_vld(food_vld),
        .q_x(q_x), .q_y(q_y), .q_hit(q_hit),
        .head_x(head_x), .head_y(head_y), .dir(dir), .length(length),
        .step(step), .eaten(eaten), .dead(dead)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Wait (bounded) for the next step or dead indication; returns negedges elapsed.
    task automatic wait_ev(input string tag, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!(step || dead) && cnt < 40);
        check({tag, "_event"}, 32'(step | dead), 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic head_chk(input string tag, input int x, input int y);
        check({tag, "_hx"}, 32'(head_x), x);
        check({tag, "_hy"}, 32'(head_y), y);
    endtask

    task automatic q_chk(input string tag, input int x, input int y, input int exp);
        q_x = 3'(x);
        q_y = 3'(y);
        #1;
        check(tag, 32'(q_hit), exp);
    endtask

    task automatic pulse_turn(input logic l, input logic r);
        turn_l = l;
        turn_r = r;
        cyc();
        turn_l = 1'b0;
        turn_r = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; turn_l = 1'b0; turn_r = 1'b0;
        food_vld = 1'b0; food_x = 3'd0; food_y = 3'd0; q_x = 3'd0; q_y = 3'd0;
        cyc(); cyc();

        // Reset values
        head_chk("rst", 0, 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_len", 32'(length), 1);
        check("rst_step", 32'(step), 0);
        check("rst_eaten", 32'(eaten), 0);
        check("rst_dead", 32'(dead), 0);
        q_chk("rst_q00", 0, 0, 1);
        rst = 1'b0;
        cyc();

        // Turns in IDLE are ignored; then straight run to the right wall
        pulse_turn(1'b1, 1'b0);
        do_start();
        for (int i = 1; i <= 7; i++) begin
            wait_ev("run", n);
            check($sformatf("run%0d_spacing", i), 32'(n), 4);
            check($sformatf("run%0d_step", i), 32'(step), 1);
            head_chk($sformatf("run%0d", i), i, 0);
        end
        cyc();
        check("run_step_pulse", 32'(step), 0);
        wait_ev("wall", n);
        check("wall_spacing", 32'(n), 3);
        check("wall_dead", 32'(dead), 1);
        check("wall_step", 32'(step), 0);
        head_chk("wall", 7, 0);
        pulse_turn(1'b0, 1'b1);
        check("dead_hold_dir", 32'(dir), 1);
        head_chk("dead_hold", 7, 0);

        // Turns
        do_start();
        check("restart_dead", 32'(dead), 0);
        head_chk("restart", 0, 0);
        wait_ev("t1", n);
        wait_ev("t2", n);
        head_chk("t2", 2, 0);
        pulse_turn(1'b0, 1'b1);
        check("turn_pending_dir", 32'(dir), 1);
        wait_ev("tr", n);
        check("tr_dir", 32'(dir), 2);
        head_chk("tr", 2, 1);
        pulse_turn(1'b1, 1'b1);
        wait_ev("tboth", n);
        check("tboth_dir", 32'(dir), 2);
        head_chk("tboth", 2, 2);
        pulse_turn(1'b1, 1'b0);
        wait_ev("tl", n);
        check("tl_dir", 32'(dir), 1);
        head_chk("tl", 3, 2);

        // Reset mid-run
        cyc(); cyc();
        rst = 1'b1;
        #1;
        head_chk("mrst", 0, 0);
        check("mrst_dir", 32'(dir), 1);
        check("mrst_len", 32'(length), 1);
        check("mrst_step", 32'(step), 0);
        check("mrst_dead", 32'(dead), 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Food: resume from (0,0) and eat at (1,0)
        food_x = 3'd1; food_y = 3'd0; food_vld = 1'b1;
        do_start();
        wait_ev("food", n);
        check("food_spacing", 32'(n), 4);
        check("food_eaten", 32'(eaten), 1);
        check("food_len", 32'(length), 2);
        head_chk("food", 1, 0);
        q_chk("food_q00", 0, 0, 1);
        q_chk("food_q10", 1, 0, 1);
        q_chk("food_q20", 2, 0, 0);

        // Grow to 5, then loop back onto the body
        for (int i = 2; i <= 4; i++) begin
            food_x = 3'(i);
            cyc();
            check($sformatf("eat_pulse%0d", i), 32'(eaten), 0);
            wait_ev("grow", n);
            check($sformatf("grow%0d_eaten", i), 32'(eaten), 1);
            check($sformatf("grow%0d_len", i), 32'(length), i + 1);
        end
        food_vld = 1'b0;
        head_chk("grow", 4, 0);
        pulse_turn(1'b0, 1'b1);
        wait_ev("loop_d", n);
        head_chk("loop_d", 4, 1);
        check("loop_d_eaten", 32'(eaten), 0);
        pulse_turn(1'b0, 1'b1);
        wait_ev("loop_l", n);
        head_chk("loop_l", 3, 1);
        check("loop_l_dir", 32'(dir), 3);
        pulse_turn(1'b0, 1'b1);
        wait_ev("loop_u", n);
        check("self_dead", 32'(dead), 1);
        check("self_step", 32'(step), 0);
        check("self_len", 32'(length), 5);
        head_chk("self", 3, 1);

        // Saturation: nine foods, length caps at 8
        do_start();
        check("sat_len0", 32'(length), 1);
        food_vld = 1'b1; food_y = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            food_x = 3'(i);
            wait_ev("sat", n);
            check($sformatf("sat%0d_eaten", i), 32'(eaten), 1);
            check($sformatf("sat%0d_len", i), 32'(length), (i + 1 > 8) ? 8 : i + 1);
        end
        head_chk("sat7", 7, 0);
        food_x = 3'd7; food_y = 3'd1;
        pulse_turn(1'b0, 1'b1);
        pulse_turn(1'b1, 1'b0);
        wait_ev("sat8", n);
        check("first_wins_dir", 32'(dir), 2);
        head_chk("sat8", 7, 1);
        check("sat8_eaten", 32'(eaten), 1);
        check("sat8_len", 32'(length), 8);
        food_y = 3'd2;
        wait_ev("sat9", n);
        head_chk("sat9", 7, 2);
        check("sat9_eaten", 32'(eaten), 1);
        check("sat9_len", 32'(length), 8);
        q_chk("sat_q10", 1, 0, 0);
        q_chk("sat_q20", 2, 0, 1);
        q_chk("sat_q71", 7, 1, 1);
        cyc();
        check("sat_eaten_off", 32'(eaten), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
